pipe_pattern_check: RTL and testbench

Parametrised PipeIn receive checker: the successor to the fixed 16-bit LFSR checker used for FrontPanel pipe benchmarking. It compares each word written through a block-throttled PipeIn endpoint against a locally generated pattern. Supported patterns are 32-bit LFSR, incrementing count and walking-one. It reports a saturating error count, a total word count and a capture of the first mismatch. It sits between an okBTPipeIn endpoint and okWireOut endpoints, in the host-interface clock domain.

---
 rtl/pipe_check_pkg.sv | 61 ++++++
 rtl/pipe_throttle.sv | 39 +++
 rtl/pipe_pattern_check.sv | 133 +++++++++++++
 tb/tb_pipe_pattern_check.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_check_pkg.sv
// -----------------------------------------------------------------------------
// pipe_check_pkg
//
// Shared definitions for the PipeIn pattern checker and the planned PipeOut
// pattern generator: pattern-mode encoding, LFSR taps, the LFSR step function
// and the expected-word function.
//
// expected_word() always returns a 64-bit value with every bit above the
// requested width forced to zero. Callers compare it against their data
// zero-extended to 64 bits, so one function serves every legal word width.
// -----------------------------------------------------------------------------
package pipe_check_pkg;

    typedef enum logic [1:0] {
        MODE_LFSR  = 2'b00,
        MODE_COUNT = 2'b01,
        MODE_WALK  = 2'b10,
        MODE_RSVD  = 2'b11   // decodes as count
    } mode_e;

    // x^32 + x^22 + x^2 + x + 1
    localparam int LFSR_TAP_A = 31;
    localparam int LFSR_TAP_B = 21;
    localparam int LFSR_TAP_C = 1;
    localparam int LFSR_TAP_D = 0;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], s[LFSR_TAP_A] ^ s[LFSR_TAP_B] ^ s[LFSR_TAP_C] ^ s[LFSR_TAP_D]};
    endfunction

    // width must be 16, 32 or 64.
    function automatic logic [63:0] expected_word(input mode_e       mode,
                                                  input logic [31:0] lfsr,
                                                  input logic [31:0] count,
                                                  input int          width);
        logic [63:0] w;
        logic [5:0]  sh;
        w  = '0;
        sh = '0;
        case (mode)
            MODE_LFSR: begin
                // 64-bit words pad the upper half with the inverted state so
                // both halves toggle.
                if (width == 64) w = {~lfsr, lfsr};
                else             w = {32'd0, lfsr};
            end
            MODE_WALK: begin
                // width is a power of two, so the modulo is a mask.
                sh = count[5:0] & 6'(width - 1);
                w  = 64'd1 << sh;
            end
            default: begin
                w = {32'd0, count};
            end
        endcase
        if (width == 16)      w = w & 64'h0000_0000_0000_FFFF;
        else if (width == 32) w = w & 64'h0000_0000_FFFF_FFFF;
        return w;
    endfunction

endpackage

// File: rtl/pipe_throttle.sv
// -----------------------------------------------------------------------------
// pipe_throttle
//
// Rotating throttle register for block-throttled pipe endpoints. The MSB is
// the ready indication; the register rotates left by one every cycle, or
// loads a new pattern when set is high.
//
// Ports:
//   clk      in   clock
//   reset_n  in   asynchronous active-low reset (register becomes all ones)
//   set      in   load val instead of rotating
//   val      in   W-bit throttle pattern
//   ready    out  throttle register MSB
// -----------------------------------------------------------------------------
module pipe_throttle #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         set,
    input  logic [W-1:0] val,
    output logic         ready
);

    logic [W-1:0] throttle;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            throttle <= '1;
        end else if (set) begin
            throttle <= val;
        end else begin
            throttle <= {throttle[W-2:0], throttle[W-1]};
        end
    end

    assign ready = throttle[W-1];

endmodule

// File: rtl/pipe_pattern_check.sv
// -----------------------------------------------------------------------------
// pipe_pattern_check
//
// Receive-side pattern checker for a block-throttled PipeIn endpoint. Each
// written word is compared with a locally generated pattern (32-bit LFSR,
// incrementing count or walking one). Reports a saturating error count, a
// wrapping word count and a capture of the first mismatch.
//
// Handshake: pipe_in_ready advertises the throttle pattern to the host, but
// every cycle with pipe_in_write high is a write whatever pipe_in_ready shows;
// there is no back-pressure on the write strobe itself.
//
// Ports:
//   clk                 in   host-interface clock
//   reset_n             in   asynchronous active-low reset (release synchronised here)
//   clear               in   synchronous restart of pattern, counters and capture
//   mode                in   00 LFSR, 01 count, 10 walking one, 11 count
//   throttle_set        in   load throttle_val into the throttle register
//   throttle_val        in   throttle pattern
//   pipe_in_write       in   word valid this cycle
//   pipe_in_data        in   received word
//   pipe_in_ready       out  throttle MSB
//   error_count         out  mismatches, saturating
//   word_count          out  accepted words, wrapping
//   first_err_valid     out  capture holds a mismatch
//   first_err_index     out  word_count of the first mismatch
//   first_err_expected  out  expected word at the first mismatch
//   first_err_received  out  received word at the first mismatch
// -----------------------------------------------------------------------------
module pipe_pattern_check
    import pipe_check_pkg::*;
#(
    parameter int          WIDTH      = 16,
    parameter int          ERR_W      = 16,
    parameter int          THROTTLE_W = 32,
    parameter logic [31:0] SEED       = 32'h0000_0001
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic [1:0]            mode,
    input  logic                  throttle_set,
    input  logic [THROTTLE_W-1:0] throttle_val,
    input  logic                  pipe_in_write,
    input  logic [WIDTH-1:0]      pipe_in_data,
    output logic                  pipe_in_ready,
    output logic [ERR_W-1:0]      error_count,
    output logic [31:0]           word_count,
    output logic                  first_err_valid,
    output logic [31:0]           first_err_index,
    output logic [WIDTH-1:0]      first_err_expected,
    output logic [WIDTH-1:0]      first_err_received
);

    if (SEED == 32'd0) begin : g_bad_seed
        $error("pipe_pattern_check: SEED must be nonzero");
    end
    if (WIDTH != 16 && WIDTH != 32 && WIDTH != 64) begin : g_bad_width
        $error("pipe_pattern_check: WIDTH must be 16, 32 or 64");
    end

    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    // Reset: assertion is immediate, release is re-timed to clk.
    logic [1:0] rst_sync;
    logic       rst_n_int;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n_int = rst_sync[1];

    pipe_throttle #(
        .W(THROTTLE_W)
    ) u_throttle (
        .clk     (clk),
        .reset_n (rst_n_int),
        .set     (throttle_set),
        .val     (throttle_val),
        .ready   (pipe_in_ready)
    );

    logic [31:0] lfsr;
    logic [63:0] exp_full;
    logic [63:0] data_ext;
    logic        mismatch;

    always_comb begin
        exp_full = expected_word(mode_e'(mode), lfsr, word_count, WIDTH);
        data_ext = 64'(pipe_in_data);
        mismatch = (exp_full != data_ext);
    end

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            lfsr               <= SEED;
            word_count         <= '0;
            error_count        <= '0;
            first_err_valid    <= 1'b0;
            first_err_index    <= '0;
            first_err_expected <= '0;
            first_err_received <= '0;
        end else if (clear) begin
            // A write coinciding with clear is dropped.
            lfsr               <= SEED;
            word_count         <= '0;
            error_count        <= '0;
            first_err_valid    <= 1'b0;
            first_err_index    <= '0;
            first_err_expected <= '0;
            first_err_received <= '0;
        end else if (pipe_in_write) begin
            // Pattern state advances in every mode so a mode switch mid-stream
            // stays in step with the sender.
            lfsr       <= lfsr_step(lfsr);
            word_count <= word_count + 32'd1;
            if (mismatch) begin
                if (error_count != ERR_MAX) begin
                    error_count <= error_count + 1'b1;
                end
                if (!first_err_valid) begin
                    first_err_valid    <= 1'b1;
                    first_err_index    <= word_count;
                    first_err_expected <= exp_full[WIDTH-1:0];
                    first_err_received <= pipe_in_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipe_pattern_check.sv
// -----------------------------------------------------------------------------
// tb_pipe_pattern_check
//
// Three checker instances share clock, reset, clear, mode and throttle
// controls; each has its own write strobe and data:
//   a: WIDTH=32, ERR_W=16
//   b: WIDTH=16, ERR_W=4
//   c: WIDTH=64, ERR_W=16
// Inputs change 1 time unit after the rising edge, outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_pipe_pattern_check;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        clear = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        throttle_set = 1'b0;
    logic [31:0] throttle_val = '0;

    logic        wr_a = 1'b0, wr_b = 1'b0, wr_c = 1'b0;
    logic [31:0] data_a = '0;
    logic [15:0] data_b = '0;
    logic [63:0] data_c = '0;

    logic        rdy_a, rdy_b, rdy_c;
    logic [15:0] err_a, err_c;
    logic [3:0]  err_b;
    logic [31:0] wc_a, wc_b, wc_c;
    logic        fev_a, fev_b, fev_c;
    logic [31:0] fei_a, fei_b, fei_c;
    logic [31:0] fee_a, fer_a;
    logic [15:0] fee_b, fer_b;
    logic [63:0] fee_c, fer_c;

    pipe_pattern_check #(.WIDTH(32), .ERR_W(16)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .clear(clear), .mode(mode),
        .throttle_set(throttle_set), .throttle_val(throttle_val),
        .pipe_in_write(wr_a), .pipe_in_data(data_a), .pipe_in_ready(rdy_a),
        .error_count(err_a), .word_count(wc_a), .first_err_valid(fev_a),
        .first_err_index(fei_a), .first_err_expected(fee_a), .first_err_received(fer_a)
    );

    pipe_pattern_check #(.WIDTH(16), .ERR_W(4)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .clear(clear), .mode(mode),
        .throttle_set(throttle_set), .throttle_val(throttle_val),
        .pipe_in_write(wr_b), .pipe_in_data(data_b), .pipe_in_ready(rdy_b),
        .error_count(err_b), .word_count(wc_b), .first_err_valid(fev_b),
        .first_err_index(fei_b), .first_err_expected(fee_b), .first_err_received(fer_b)
    );

    pipe_pattern_check #(.WIDTH(64), .ERR_W(16)) u_dut_c (
        .clk(clk), .reset_n(reset_n), .clear(clear), .mode(mode),
        .throttle_set(throttle_set), .throttle_val(throttle_val),
        .pipe_in_write(wr_c), .pipe_in_data(data_c), .pipe_in_ready(rdy_c),
        .error_count(err_c), .word_count(wc_c), .first_err_valid(fev_c),
        .first_err_index(fei_c), .first_err_expected(fee_c), .first_err_received(fer_c)
    );

    // ---------------- scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference LFSR, x^32 + x^22 + x^2 + x + 1.
    function automatic logic [31:0] ref_lfsr(input logic [31:0] s);
        logic fb;
        fb = s[31] ^ s[21] ^ s[1] ^ s[0];
        return (s << 1) | {31'd0, fb};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic write_a(input logic [31:0] d);
        wr_a = 1'b1; data_a = d; tick(); wr_a = 1'b0;
    endtask

    task automatic write_b(input logic [15:0] d);
        wr_b = 1'b1; data_b = d; tick(); wr_b = 1'b0;
    endtask

    task automatic write_c(input logic [63:0] d);
        wr_c = 1'b1; data_c = d; tick(); wr_c = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0]  mode;
        logic [31:0] data;
        logic [15:0] exp_err;
        logic [31:0] exp_wc;
        logic        exp_fev;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [31:0] m;
        logic [63:0] w;

        // LFSR from seed 1: 1, 3, 6, D, 1B, 36, 6D, DB, 1B6, 36D ...
        vecs[0] = '{2'b00, 32'h0000_0001, 16'd0,  32'd1, 1'b0};
        vecs[1] = '{2'b00, 32'h0000_0003, 16'd0,  32'd2, 1'b0};
        vecs[2] = '{2'b00, 32'h0000_0006, 16'd0,  32'd3, 1'b0};
        vecs[3] = '{2'b00, 32'h0000_000D, 16'd0,  32'd4, 1'b0};
        vecs[4] = '{2'b00, 32'h0000_DEAD, 16'd1,  32'd5, 1'b1}; // expects 0x1B
        vecs[5] = '{2'b01, 32'h0000_0005, 16'd1,  32'd6, 1'b1}; // count
        vecs[6] = '{2'b10, 32'h0000_0040, 16'd1,  32'd7, 1'b1}; // walk, 1<<6
        vecs[7] = '{2'b11, 32'h0000_0007, 16'd1,  32'd8, 1'b1}; // reserved = count
        vecs[8] = '{2'b00, 32'h0000_01B6, 16'd1,  32'd9, 1'b1}; // LFSR kept stepping
        vecs[9] = '{2'b00, 32'h0000_0000, 16'd2, 32'd10, 1'b1}; // expects 0x36D

        do_reset();
        check("reset ready",     64'(rdy_a), 64'd1);
        check("reset err",       64'(err_a), 64'd0);
        check("reset wc",        64'(wc_a),  64'd0);
        check("reset fev",       64'(fev_a), 64'd0);
        check("reset fei",       64'(fei_a), 64'd0);

        // Table: LFSR, mode switching, second mismatch.
        for (int i = 0; i < 10; i++) begin
            mode = vecs[i].mode;
            write_a(vecs[i].data);
            check($sformatf("vec%0d err", i), 64'(err_a), 64'(vecs[i].exp_err));
            check($sformatf("vec%0d wc", i),  64'(wc_a),  64'(vecs[i].exp_wc));
            check($sformatf("vec%0d fev", i), 64'(fev_a), 64'(vecs[i].exp_fev));
        end
        check("a cap index",    64'(fei_a), 64'd4);
        check("a cap expected", 64'(fee_a), 64'h1B);
        check("a cap received", 64'(fer_a), 64'hDEAD);

        // Clear in the same cycle as a write: write is dropped.
        mode  = 2'b00;
        clear = 1'b1; wr_a = 1'b1; data_a = 32'h1;
        tick();
        clear = 1'b0; wr_a = 1'b0;
        check("clr wc",  64'(wc_a),  64'd0);
        check("clr err", 64'(err_a), 64'd0);
        check("clr fev", 64'(fev_a), 64'd0);
        check("clr fei", 64'(fei_a), 64'd0);
        check("clr fee", 64'(fee_a), 64'd0);
        check("clr fer", 64'(fer_a), 64'd0);
        write_a(32'h0000_0001);
        check("post clr err", 64'(err_a), 64'd0);
        check("post clr wc",  64'(wc_a),  64'd1);

        // Long LFSR run so the high taps come into play.
        m = 32'h0000_0003;
        for (int i = 0; i < 60; i++) begin
            exp_q.push_back({32'd0, m});
            m = ref_lfsr(m);
        end
        while (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            write_a(w[31:0]);
        end
        check("lfsr run err", 64'(err_a), 64'd0);
        check("lfsr run wc",  64'(wc_a),  64'd61);

        // Throttle 0x0000FFFF: 16 low, 16 high, period 32; clear has no effect.
        throttle_val = 32'h0000_FFFF;
        throttle_set = 1'b1;
        tick();
        throttle_set = 1'b0;
        for (int k = 0; k < 64; k++) begin
            check($sformatf("throttle k%0d", k), 64'(rdy_a), 64'((k % 32) >= 16));
            clear = (k == 5);
            tick();
        end
        clear = 1'b0;

        // WIDTH 16, count mode, one bad word.
        mode = 2'b01;
        pulse_clear();
        write_b(16'h0000);
        write_b(16'h0001);
        write_b(16'h0002);
        write_b(16'h0099);
        write_b(16'h0004);
        check("b err",      64'(err_b), 64'd1);
        check("b wc",       64'(wc_b),  64'd5);
        check("b fev",      64'(fev_b), 64'd1);
        check("b fei",      64'(fei_b), 64'd3);
        check("b fee",      64'(fee_b), 64'h0003);
        check("b fer",      64'(fer_b), 64'h0099);

        // ERR_W=4 saturation: 20 bad words after clear.
        pulse_clear();
        for (int i = 0; i < 20; i++) begin
            write_b(16'(i) ^ 16'hFFFF);
            if (i == 13) check("b err at 14", 64'(err_b), 64'd14);
        end
        check("b sat err", 64'(err_b), 64'd15);
        check("b sat wc",  64'(wc_b),  64'd20);
        check("b sat fev", 64'(fev_b), 64'd1);
        check("b sat fei", 64'(fei_b), 64'd0);
        check("b sat fee", 64'(fee_b), 64'h0000);
        check("b sat fer", 64'(fer_b), 64'hFFFF);

        // WIDTH 64 LFSR: {~lfsr, lfsr}.
        mode = 2'b00;
        pulse_clear();
        write_c(64'hFFFF_FFFE_0000_0001);
        check("c lfsr err0", 64'(err_c), 64'd0);
        write_c(64'h0);
        check("c lfsr err1", 64'(err_c), 64'd1);
        check("c lfsr fee",  fee_c,      64'hFFFF_FFFC_0000_0003);
        check("c lfsr fei",  64'(fei_c), 64'd1);

        // WIDTH 64 walking one across the wrap.
        mode = 2'b10;
        pulse_clear();
        for (int i = 0; i < 66; i++) begin
            write_c(64'd1 << (i % 64));
        end
        check("c walk err", 64'(err_c), 64'd0);
        check("c walk wc",  64'(wc_c),  64'd66);
        write_c(64'h0);
        check("c walk fee", fee_c,      64'h4);
        check("c walk fei", 64'(fei_c), 64'd66);
        check("c walk fer", fer_c,      64'h0);

        // Asynchronous reset assertion mid-stream.
        reset_n = 1'b0;
        #1;
        check("async wc",  64'(wc_c),  64'd0);
        check("async err", 64'(err_c), 64'd0);
        check("async fev", 64'(fev_c), 64'd0);
        tick();
        reset_n = 1'b1;
        repeat (2) tick();
        check("post reset ready", 64'(rdy_a), 64'd1);
        check("post reset wc",    64'(wc_a),  64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
